// File: rtl/fetch_stall_ctrl.sv
// Fetch-stage stall/redirect controller: owns PC, the IF/ID register and the RUN/HOLD/DRAIN/HALTED FSM.
// Optional stall cycle counter and stall_cycles port are built only when FETCH_STALL_COUNT_EN is defined.
module fetch_stall_ctrl #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchStall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic [15:0] instr_in,
  output logic [15:0] pc,
  output logic [15:0] instr_ifid,
  output logic [15:0] pc2_ifid,
  output logic        valid_ifid,
  output logic        bubble_idex,
`ifdef FETCH_STALL_COUNT_EN
  output logic [15:0] stall_cycles,
`endif
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HOLD   = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: redirect beats branchStall, which beats stall, which beats halt
  always_comb begin
    state_d = state_q;
    if (state_q != HALTED) begin
      if (redirect_valid)             state_d = branchStall ? DRAIN : RUN;
      else if (branchStall)           state_d = DRAIN;
      else if (state_q == DRAIN)      state_d = DRAIN;
      else if (stall)                 state_d = HOLD;
      else if (halt && valid_q)       state_d = HALTED;
      else                            state_d = RUN;
    end
  end

  // Datapath next values follow the same priority as the state decision
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    if (state_q != HALTED) begin
      if (redirect_valid) begin
        pc_d    = redirect_pc;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (branchStall || state_q == DRAIN) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (!stall && !(halt && valid_q)) begin
        pc_d    = pc_inc;
        instr_d = instr_in;
        pc2_d   = pc_inc;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

  // Outputs
  always_comb begin
    bubble_idex = stall || (state_q == DRAIN) || (state_q == HALTED);
    state_o     = state_q;
  end

  assign pc         = pc_q;
  assign instr_ifid = instr_q;
  assign pc2_ifid   = pc2_q;
  assign valid_ifid = valid_q;

`ifdef FETCH_STALL_COUNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (bubble_idex && state_q != HALTED) stall_cycles_d = sat_inc16(stall_cycles_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cycles_q <= 16'h0000;
    else        stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl: free fetch, stall hold, drain/redirect, wrap, halt and reset override.
module tb_fetch_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, stall, branchStall, redirect_valid, halt;
  logic [15:0] redirect_pc, instr_in;
  logic [15:0] pc, instr_ifid, pc2_ifid;
  logic        valid_ifid, bubble_idex;
  logic [1:0]  state_o;
`ifdef FETCH_STALL_COUNT_EN
  logic [15:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branchStall(branchStall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .instr_in(instr_in), .pc(pc), .instr_ifid(instr_ifid), .pc2_ifid(pc2_ifid),
    .valid_ifid(valid_ifid), .bubble_idex(bubble_idex),
`ifdef FETCH_STALL_COUNT_EN
    .stall_cycles(stall_cycles),
`endif
    .state_o(state_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branchStall = 1'b0; redirect_valid = 1'b0;
    halt = 1'b0; redirect_pc = 16'h0000; instr_in = 16'h4001;
    step(2);
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_instr", instr_ifid, 16'h0800);
    check_eq("rst_pc2", pc2_ifid, 16'h0000);
    check_eq("rst_valid", valid_ifid, 1'b0);
    check_eq("rst_state", state_o, 2'b00);
    check_eq("rst_bubble", bubble_idex, 1'b0);

    // free running fetch
    rst_n = 1'b1;
    step();
    check_eq("run1_pc", pc, 16'h0002);
    check_eq("run1_instr", instr_ifid, 16'h4001);
    check_eq("run1_pc2", pc2_ifid, 16'h0002);
    check_eq("run1_valid", valid_ifid, 1'b1);
    step();
    check_eq("run2_pc", pc, 16'h0004);

    // two-cycle stall at pc=0004
    stall = 1'b1; instr_in = 16'h4002; #1;
    check_eq("stall_bubble0", bubble_idex, 1'b1);
    step();
    check_eq("hold1_state", state_o, 2'b01);
    check_eq("hold1_pc", pc, 16'h0004);
    check_eq("hold1_instr", instr_ifid, 16'h4001);
    check_eq("hold1_bubble", bubble_idex, 1'b1);
    step();
    check_eq("hold2_pc", pc, 16'h0004);
    stall = 1'b0; #1;
    check_eq("hold_rel_bubble", bubble_idex, 1'b0);
    step();
    check_eq("unhold_pc", pc, 16'h0006);
    check_eq("unhold_instr", instr_ifid, 16'h4002);
    check_eq("unhold_state", state_o, 2'b00);

    // branch drain then redirect
    branchStall = 1'b1;
    step();
    check_eq("drain_state", state_o, 2'b10);
    check_eq("drain_instr", instr_ifid, 16'h0800);
    check_eq("drain_valid", valid_ifid, 1'b0);
    check_eq("drain_pc", pc, 16'h0006);
    check_eq("drain_bubble", bubble_idex, 1'b1);
    step(2);
    check_eq("drain3_pc", pc, 16'h0006);
    branchStall = 1'b0; #1;
    step();
    check_eq("drain_wait_state", state_o, 2'b10);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    check_eq("redir_pc", pc, 16'h0040);
    check_eq("redir_state", state_o, 2'b00);
    check_eq("redir_valid", valid_ifid, 1'b0);
    redirect_valid = 1'b0; instr_in = 16'h4003;
    step();
    check_eq("post_redir_pc", pc, 16'h0042);
    check_eq("post_redir_instr", instr_ifid, 16'h4003);

    // 16-bit wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    check_eq("wrap_pre_pc", pc, 16'hFFFE);
    step();
    check_eq("wrap_pc", pc, 16'h0000);
    check_eq("wrap_pc2", pc2_ifid, 16'h0000);

    // redirect outranks stall; redirect with branchStall goes to DRAIN
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step();
    check_eq("redir_stall_pc", pc, 16'h0100);
    check_eq("redir_stall_state", state_o, 2'b00);
    stall = 1'b0; branchStall = 1'b1; redirect_pc = 16'h0200;
    step();
    check_eq("redir_bs_pc", pc, 16'h0200);
    check_eq("redir_bs_state", state_o, 2'b10);
    branchStall = 1'b0; redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    step();
    check_eq("refetch_pc", pc, 16'h0102);
    check_eq("refetch_valid", valid_ifid, 1'b1);

    // halt with stall: stall wins, then halt
    halt = 1'b1; stall = 1'b1;
    step();
    check_eq("halt_stall_state", state_o, 2'b01);
    stall = 1'b0;
    step();
    check_eq("halted_state", state_o, 2'b11);
    check_eq("halted_pc", pc, 16'h0102);
    halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0300; branchStall = 1'b1;
    step(10);
    check_eq("halted10_pc", pc, 16'h0102);
    check_eq("halted10_state", state_o, 2'b11);
    check_eq("halted10_bubble", bubble_idex, 1'b1);
    rst_n = 1'b0;
    step();
    check_eq("halt_rst_pc", pc, 16'h0000);
    check_eq("halt_rst_state", state_o, 2'b00);

    // reset beats redirect mid-drain
    rst_n = 1'b1; redirect_valid = 1'b0;
    step();
    check_eq("drain2_state", state_o, 2'b10);
    rst_n = 1'b0; redirect_valid = 1'b1;
    step();
    check_eq("drain_rst_pc", pc, 16'h0000);
    check_eq("drain_rst_state", state_o, 2'b00);
    redirect_valid = 1'b0; branchStall = 1'b0;

`ifdef FETCH_STALL_COUNT_EN
    check_eq("cnt_rst", stall_cycles, 16'h0000);
    rst_n = 1'b1; stall = 1'b1;
    step(5);
    stall = 1'b0;
    step();
    check_eq("cnt_5", stall_cycles, 16'h0005);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
